strobe_uart_tx: RTL and testbench
=================================

STROBE_UART_TX -- requirements
Module: strobe_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame (legal 5..9).
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-003 clk  input  1  block clock; all state changes on rising edge.
REQ-004 rst_l  input  1  reset, asynchronous, active-low.
REQ-005 strobe  input  1  bit-rate tick from upstream strobe generator, one-cycle pulse.
REQ-006 in_data  input  DATA_WIDTH  payload word, LSB transmitted first.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 tx_out  output  1  serial line, idle high.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse when last stop bit completes.

Function
REQ-012 States: IDLE, ARMED, START, DATA, PARITY, STOP.
REQ-013 in_ready = 1 only in IDLE; combinational from state.
REQ-014 IDLE and in_valid=1 -> latch in_data into shift register, go ARMED; strobe in the accept cycle is ignored.
REQ-015 ARMED, strobe=1 -> tx_out=0, go START; tx_out stays 1 while ARMED.
REQ-016 START, strobe=1 -> tx_out=shift[0], bit counter=0, go DATA.
REQ-017 DATA, strobe=1, counter<DATA_WIDTH-1 -> shift right one, tx_out=next bit, counter+1.
REQ-018 DATA, strobe=1, counter=DATA_WIDTH-1 -> PARITY with tx_out=parity bit if enabled, else STOP with tx_out=1.
REQ-019 PARITY, strobe=1 -> tx_out=1, go STOP.
REQ-020 STOP, strobe=1 -> stop counter+1; when STOP_BITS stop intervals complete -> IDLE, frame_done=1 for that one cycle, tx_out stays 1.
REQ-021 Every line symbol lasts exactly one strobe period; tx_out changes only on cycles with strobe=1 (except reset).
REQ-022 strobe=0 in any non-IDLE state -> no state, counter or output change.
REQ-023 in_valid while busy -> ignored, word not consumed; no back-to-back acceptance in the frame_done cycle (IDLE entered next edge).
REQ-024 Bit counter width $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
REQ-025 strobe held high continuously -> one symbol per clock, still legal.

Reset
REQ-026 rst_l low -> state IDLE, tx_out=1, frame_done=0, counters 0, shift register 0, immediately and asynchronously.
REQ-027 Reset mid-frame aborts the frame; no frame_done; line returns high; in_ready=1 on first edge after release.

Configuration
REQ-028 Macro STROBE_UART_TX_PARITY_EN defined -> PARITY state present, even parity (XOR of payload) sent after last data bit.
REQ-029 Macro undefined -> PARITY state and parity logic absent; DATA goes directly to STOP; frame one symbol shorter.

Structure
REQ-030 Shared package strobe_uart_pkg holds state enum typedef and idle-level/start-level constants.
REQ-031 One sub-module natural: uart_tx_shifter (load, shift-on-enable, LSB out, parity XOR); FSM stays in top.

Verification
REQ-032 Upstream STROBE_PERIOD=3, no parity, send 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each held 3 clocks; frame_done once after stop.
REQ-033 Parity enabled, send 0xA5 then 0x01 -> parity bits 0 then 1 before stop.
REQ-034 in_valid held high with 0x3C,0x55 -> second word accepted only in IDLE after frame_done; no gap shorter than one stop bit.
REQ-035 rst_l pulsed low during DATA bit 4 -> tx_out=1 immediately, busy=0, no frame_done, next 0xFF frame correct.
REQ-036 STOP_BITS=2, strobe tied high -> 0x00 frame is 1 start, 8 zeros, 2 ones, 11 clocks total; frame_done on 11th.

Source files
------------

// File: rtl/strobe_uart_pkg.sv
// Shared types and line levels for the strobe-paced UART transmitter.
// STROBE_UART_TX_PARITY_EN adds the even-parity symbol to the frame.
package strobe_uart_pkg;

`ifdef STROBE_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, ARMED, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, ARMED, START, DATA, STOP
  } state_e;
`endif

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/strobe_uart_tx_shifter.sv
// Payload shift register: load, shift right on enable, LSB first.
// STROBE_UART_TX_PARITY_EN keeps the even parity of the loaded word.
module uart_tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
`ifdef STROBE_UART_TX_PARITY_EN
  output logic         par_o,
`endif
  output logic         lsb_o,
  output logic         nxt_o
);

  logic [W-1:0] sh_q, sh_d;

  // next shift contents: load wins over shift
  always_comb begin
    sh_d = sh_q;
    if (load_i)
      sh_d = data_i;
    else if (shift_i)
      sh_d = {1'b0, sh_q[W-1:1]};
  end

  // shift register storage
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      sh_q <= '0;
    else
      sh_q <= sh_d;
  end

  assign lsb_o = sh_q[0];
  assign nxt_o = sh_q[1];

`ifdef STROBE_UART_TX_PARITY_EN
  logic par_q;

  // parity captured at load, before bits shift out
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      par_q <= 1'b0;
    else if (load_i)
      par_q <= ^data_i;
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/strobe_uart_tx.sv
// UART transmitter paced by an external bit-rate strobe.
// STROBE_UART_TX_PARITY_EN adds an even-parity symbol after the data.
module strobe_uart_tx
  import strobe_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          load, shift, lsb, nxt;
`ifdef STROBE_UART_TX_PARITY_EN
  logic          par;
`endif

  uart_tx_shifter #(.W(DATA_WIDTH)) u_shift (
    .clk    (clk),
    .rst_l  (rst_l),
    .load_i (load),
    .shift_i(shift),
    .data_i (in_data),
`ifdef STROBE_UART_TX_PARITY_EN
    .par_o  (par),
`endif
    .lsb_o  (lsb),
    .nxt_o  (nxt)
  );

  // state, counters and registered line level
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  // next state: every move past ARMED waits for a strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (strobe) begin
          tx_d    = START_LVL;
          state_d = START;
        end
      end
      START: begin
        if (strobe) begin
          tx_d    = lsb;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (strobe) begin
          if (cnt_q == LAST) begin
`ifdef STROBE_UART_TX_PARITY_EN
            tx_d    = par;
            state_d = PARITY;
`else
            tx_d    = IDLE_LVL;
            stop_d  = 1'b0;
            state_d = STOP;
`endif
          end else begin
            shift = 1'b1;
            tx_d  = nxt;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef STROBE_UART_TX_PARITY_EN
      PARITY: begin
        if (strobe) begin
          tx_d    = IDLE_LVL;
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (strobe) begin
          if (stop_q == SLAST) begin
            stop_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    frame_done = (state_q == STOP) && strobe
                 && (stop_q == SLAST);
  end

  assign tx_out = tx_q;

endmodule

// File: tb/tb_strobe_uart_tx.sv
// Bench for strobe_uart_tx: symbol-list model checked every cycle.
// Honours STROBE_UART_TX_PARITY_EN when defined.
module tb_strobe_uart_tx;

  localparam int DW = 8;
  localparam int SB = 2;
`ifdef STROBE_UART_TX_PARITY_EN
  localparam int P = 1;
  localparam logic [31:0] LIT_A5 = 32'hD4A;
  localparam logic [31:0] LIT_01 = 32'hE02;
  localparam logic [31:0] LIT_FF = 32'hDFE;
  localparam logic [31:0] LIT_00 = 32'hC00;
`else
  localparam int P = 0;
  localparam logic [31:0] LIT_A5 = 32'h74A;
  localparam logic [31:0] LIT_01 = 32'h602;
  localparam logic [31:0] LIT_FF = 32'h7FE;
  localparam logic [31:0] LIT_00 = 32'h600;
`endif
  localparam int NSYM = 1 + DW + P + SB;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       strobe;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  strobe_uart_tx #(
    .DATA_WIDTH(DW),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .strobe    (strobe),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  // frame as a list of line symbols, bit i = symbol i
  function automatic logic [15:0] frame_bits(input logic [7:0] w);
    logic [15:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = w[i];
    if (P == 1) f[1+DW] = ^w;
    for (int k = 0; k < SB; k++) f[1+DW+P+k] = 1'b1;
    return f;
  endfunction

  // model: idle / armed (pos -1) / showing symbol pos
  bit          m_act = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_bits = '0;

  always @(posedge clk) begin
    if (!rst_l) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act  <= 1'b1;
        m_pos  <= -1;
        m_bits <= frame_bits(in_data);
      end
    end else if (strobe) begin
      if (m_pos == NSYM - 1) m_act <= 1'b0;
      else m_pos <= m_pos + 1;
    end
  end

  always @(negedge clk) begin
    logic eb, et, ef;
    eb = rst_l && m_act;
    et = (eb && m_pos >= 0) ? m_bits[m_pos] : 1'b1;
    ef = eb && strobe && (m_pos == NSYM - 1);
    chk("busy", busy, eb);
    chk("in_ready", in_ready, !eb);
    chk("tx_out", tx_out, et);
    chk("frame_done", frame_done, ef);
  end

  task automatic step(input logic s, input logic v,
                      input logic [7:0] d);
    @(posedge clk);
    #1;
    strobe   = s;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_l    = 1'b0;
    strobe   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_async_tx", tx_out, 1);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_fd", frame_done, 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic send(input logic [7:0] w, input int per,
                      input int abort_at, output logic [15:0] rec,
                      output int nfd, output int fdi);
    int   ns;
    bit   ps, fin;
    logic s;
    ns = 0; ps = 0; fin = 0;
    rec = '0; nfd = 0; fdi = -1;
    step(1'b0, 1'b1, w);
    @(negedge clk);
    chk("send_ready", in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      s = ((i % per) == per - 1);
      step(s, 1'b0, w);
      @(negedge clk);
      if (ps) begin
        if (ns < 16) rec[ns] = tx_out;
        ns++;
      end
      if (fin) break;
      if (abort_at > 0 && ns == abort_at) begin
        reset_pulse();
        break;
      end
      if (frame_done) begin
        nfd++;
        fdi = i;
        fin = 1;
      end
      ps = s;
    end
    if (abort_at == 0) chk("send_end", fin, 1);
  endtask

  initial begin
    logic [15:0] rec;
    int nfd, fdi, acc, hfd;

    rst_l    = 1'b0;
    strobe   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_fd", frame_done, 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    chk("model_a5", {16'h0, frame_bits(8'hA5)}, LIT_A5);

    send(8'hA5, 3, 0, rec, nfd, fdi);
    chk("a5_syms", {16'h0, rec} & ((32'h1 << NSYM) - 1), LIT_A5);
    chk("a5_fd_count", nfd, 1);

    send(8'h01, 2, 0, rec, nfd, fdi);
    chk("x01_syms", {16'h0, rec} & ((32'h1 << NSYM) - 1), LIT_01);
    chk("x01_fd_count", nfd, 1);

    acc = 0;
    hfd = 0;
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) acc++;
      if (frame_done) hfd++;
      if (hfd == 2) break;
      step(1'(i % 2), acc < 2, (acc == 0) ? 8'h3C : 8'h55);
    end
    step(1'b0, 1'b0, 8'h00);
    chk("hold_accepts", acc, 2);
    chk("hold_frames", hfd, 2);

    send(8'hC3, 3, 6, rec, nfd, fdi);
    chk("abort_fd_count", nfd, 0);
    @(negedge clk);
    chk("abort_ready", in_ready, 1);
    send(8'hFF, 3, 0, rec, nfd, fdi);
    chk("ff_syms", {16'h0, rec} & ((32'h1 << NSYM) - 1), LIT_FF);
    chk("ff_fd_count", nfd, 1);

    send(8'h00, 1, 0, rec, nfd, fdi);
    chk("x00_syms", {16'h0, rec} & ((32'h1 << NSYM) - 1), LIT_00);
    chk("x00_clocks", fdi, NSYM);

    for (int c = 0; c < 3000; c++) begin
      int   mode;
      logic s;
      mode = (c / 250) % 3;
      if (mode == 0) s = 1'b1;
      else if (mode == 1) s = ($urandom % 3) == 0;
      else s = (c % 4) == 0;
      if ($urandom % 400 == 0)
        reset_pulse();
      else
        step(s, 1'($urandom % 2), 8'($urandom));
    end
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
